tt_um_monishvr_fifo: RTL and testbench
======================================

Name: tt_um_monishvr_fifo

Overview:
Synchronous 4-bit-wide, 8-deep FIFO packaged as a TinyTapeout user tile. Write/read strobes and write data arrive on ui_in; read data and full/empty flags leave on uo_out. The bidirectional pins are unused and held as inputs.

Parameters:
DATA_W, 4, FIFO word width (fixed by pin map; not user-overridable at the top level)
DEPTH, 8, number of entries (power of two; pointer width = log2(DEPTH), count width = log2(DEPTH)+1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; ignored (design always active)
ui_in  input  8  [2]=wr_en, [3]=rd_en, [7:4]=write data, [1:0] unused
uo_out  output  8  [0]=full, [1]=empty, [5:2]=read data, [7:6]=status (see Optional Feature)
uio_in  input  8  unused
uio_out  output  8  constant 0
uio_oe  output  8  constant 0 (all bidirectional pins are inputs)

Behaviour:
- One clock; reset is asynchronous and active-low on rst_n. Asserting it clears wr_ptr, rd_ptr, count and the read-data register to 0. While in reset: full=0, empty=1, read data=0, uo_out[7:6]=0.
- All state updates occur on the rising edge of clk; strobes are sampled level-per-cycle (each cycle with a strobe high is one operation).
- Write accepted when wr_en=1 and (count<DEPTH, or a read is accepted in the same cycle): mem[wr_ptr]<=ui_in[7:4]; wr_ptr increments modulo DEPTH.
- Read accepted when rd_en=1 and count>0: read-data register <= mem[rd_ptr]; rd_ptr increments modulo DEPTH. Data appears on uo_out[5:2] after the same edge and holds until the next accepted read.
- Rejected read (empty): the read-data register holds its value. Rejected write (full with no read): the data is dropped and memory is unchanged.
- Simultaneous accepted read and write: both pointers advance and count is unchanged. When empty, only the write occurs; the read is rejected (no fall-through).
- count: +1 on write only, -1 on read only, unchanged otherwise.
- full = (count==DEPTH), empty = (count==0), decoded from registered count (no combinational path from ui_in).
- Order is strict first-in first-out across pointer wrap-around.
- Memory contents are not reset.

Optional Feature:
FIFO_STICKY_FLAGS_EN. When defined: uo_out[6] = sticky overflow, set when wr_en=1 while a write is rejected; uo_out[7] = sticky underflow, set when rd_en=1 while empty. Both clear only on reset. When not defined: uo_out[7:6] are constant 0 and no flag registers exist.

Decomposition:
- Package fifo_pkg: DATA_W, DEPTH, PTR_W, CNT_W constants and ui_in/uo_out bit-index constants (WR_EN_BIT=2, RD_EN_BIT=3, DIN_LSB=4, FULL_BIT=0, EMPTY_BIT=1, DOUT_LSB=2).
- One sub-module, fifo_core: generic clk/rst_n/wr_en/rd_en/din/dout/full/empty FIFO.
- The top level does only pin mapping, tie-offs and the optional sticky flags.

Test Plan:
- Reset -> uo_out=8'b0000_0010 (empty=1, full=0, dout=0); uio_oe=0, uio_out=0.
- Write 0xA for one cycle -> empty=0. Then read one cycle -> uo_out[5:2]=0xA and empty=1. A further read -> dout stays 0xA.
- Write 0xC, then read -> dout=0xC. Confirms pointer advance and FIFO order after the first entry.
- Write 0..7 -> full=1 after the 8th write. 9th write of 0xF is dropped (overflow flag=1 if enabled). Eight reads return 0..7 in order, then empty=1.
- With 3 entries stored, assert wr_en and rd_en together for 4 cycles -> count stays 3 and outputs follow FIFO order across pointer wrap. When full, simultaneous rd+wr keeps full=1.
- Assert rst_n low mid-stream with 5 entries -> flags and dout reset immediately, without waiting for a clock edge. After release, a read is rejected (empty=1) and dout=0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared constants for the TinyTapeout FIFO tile: word/depth sizing and the
// bit positions used on ui_in / uo_out.
// Optional build macro: FIFO_STICKY_FLAGS_EN (sticky overflow/underflow on uo_out[7:6]).
package fifo_pkg;

  // Word width is fixed by the pin map (4 data bits in, 4 data bits out).
  localparam int DATA_W = 4;
  // Number of entries; must be a power of two so pointers wrap naturally.
  localparam int DEPTH  = 8;
  localparam int PTR_W  = $clog2(DEPTH);
  // One extra bit so that "DEPTH entries stored" is representable.
  localparam int CNT_W  = PTR_W + 1;

  // ui_in bit map
  localparam int WR_EN_BIT = 2;
  localparam int RD_EN_BIT = 3;
  localparam int DIN_LSB   = 4;

  // uo_out bit map
  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int DOUT_LSB  = 2;
  localparam int OVF_BIT   = 6;
  localparam int UNF_BIT   = 7;

endpackage : fifo_pkg

// File: rtl/fifo_core.sv
// Generic synchronous FIFO: registered read data, flags decoded from the
// registered occupancy count, no fall-through on an empty read.
//
// Handshake: i_wr_en / i_rd_en are level strobes sampled on every rising edge.
// A write is accepted when not full, or when a read is accepted in the same
// cycle; a read is accepted when not empty. Rejected operations are reported
// on o_wr_drop / o_rd_drop in the same cycle and otherwise have no effect.
module fifo_core
  import fifo_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr_en,
  input  logic              i_rd_en,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_wr_drop,
  output logic              o_rd_drop
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_dout;

  logic w_full;
  logic w_empty;
  logic w_rd_accept;
  logic w_wr_accept;

  // Flags come only from the registered count, so there is no path from the strobes.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // A read frees a slot in the same cycle, which lets a write proceed while full.
  assign w_rd_accept = i_rd_en & ~w_empty;
  assign w_wr_accept = i_wr_en & (~w_full | w_rd_accept);

  // Storage array; contents are intentionally left unreset.
  always_ff @(posedge i_clk) begin
    if (w_wr_accept) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  // Pointer advance; PTR_W-bit pointers wrap modulo DEPTH on their own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_accept) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_rd_accept) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Occupancy: +1 on write only, -1 on read only, unchanged on both or neither.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_accept, w_rd_accept})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-data register: updates only on an accepted read, holds otherwise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dout <= '0;
    end else if (w_rd_accept) begin
      r_dout <= r_mem[r_rd_ptr];
    end
  end

  assign o_dout    = r_dout;
  assign o_full    = w_full;
  assign o_empty   = w_empty;
  assign o_wr_drop = i_wr_en & ~w_wr_accept;
  assign o_rd_drop = i_rd_en & ~w_rd_accept;

endmodule : fifo_core

// File: rtl/tt_um_monishvr_fifo.sv
// TinyTapeout tile wrapper around fifo_core: pin mapping, tie-offs and the
// optional sticky status flags.
// Optional build macro: FIFO_STICKY_FLAGS_EN -- when defined, uo_out[6] is a
// sticky overflow flag and uo_out[7] a sticky underflow flag (cleared only by
// reset); otherwise uo_out[7:6] are constant 0.
module tt_um_monishvr_fifo
  import fifo_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  logic [DATA_W-1:0] w_dout;
  logic              w_full;
  logic              w_empty;
  logic              w_wr_drop;
  logic              w_rd_drop;
  logic              w_ovf;
  logic              w_unf;
  logic              w_unused;

  fifo_core u_core (
    .i_clk     (clk),
    .i_rst_n   (rst_n),
    .i_wr_en   (ui_in[WR_EN_BIT]),
    .i_rd_en   (ui_in[RD_EN_BIT]),
    .i_din     (ui_in[DIN_LSB +: DATA_W]),
    .o_dout    (w_dout),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_wr_drop (w_wr_drop),
    .o_rd_drop (w_rd_drop)
  );

`ifdef FIFO_STICKY_FLAGS_EN
  logic r_ovf;
  logic r_unf;

  // Sticky flags latch any rejected strobe and only reset clears them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      if (w_wr_drop) r_ovf <= 1'b1;
      if (w_rd_drop) r_unf <= 1'b1;
    end
  end

  assign w_ovf    = r_ovf;
  assign w_unf    = r_unf;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[1:0]};
`else
  assign w_ovf    = 1'b0;
  assign w_unf    = 1'b0;
  assign w_unused = &{1'b0, ena, uio_in, ui_in[1:0], w_wr_drop, w_rd_drop};
`endif

  // Output pin map assembled from the core status and read data.
  always_comb begin
    uo_out                      = '0;
    uo_out[FULL_BIT]            = w_full;
    uo_out[EMPTY_BIT]           = w_empty;
    uo_out[DOUT_LSB +: DATA_W]  = w_dout;
    uo_out[OVF_BIT]             = w_ovf;
    uo_out[UNF_BIT]             = w_unf;
  end

  // Bidirectional pins are all inputs and never driven.
  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule : tt_um_monishvr_fifo

// File: tb/tb_tt_um_monishvr_fifo.sv
// Self-checking bench for tt_um_monishvr_fifo: directed scenarios plus a
// randomized stream, compared against a queue-based reference model.
module tb_tt_um_monishvr_fifo;

  localparam int MODEL_DEPTH = 8;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks;
  int failures;

  // Reference model state
  logic [3:0] exp_q[$];
  logic [3:0] m_dout;
  logic       m_ovf;
  logic       m_unf;

  tt_um_monishvr_fifo dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_uo();
    logic [7:0] v;
    v      = 8'h00;
    v[0]   = (exp_q.size() == MODEL_DEPTH);
    v[1]   = (exp_q.size() == 0);
    v[5:2] = m_dout;
`ifdef FIFO_STICKY_FLAGS_EN
    v[6]   = m_ovf;
    v[7]   = m_unf;
`endif
    return v;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_dout = 4'h0;
    m_ovf  = 1'b0;
    m_unf  = 1'b0;
  endtask

  // FIFO rules: read needs an entry; write needs room or a same-cycle read.
  task automatic model_step(input logic wr, input logic rd, input logic [3:0] din);
    logic rd_ok;
    logic wr_ok;
    rd_ok = rd && (exp_q.size() > 0);
    wr_ok = wr && ((exp_q.size() < MODEL_DEPTH) || rd_ok);
    if (wr && !wr_ok) m_ovf = 1'b1;
    if (rd && !rd_ok) m_unf = 1'b1;
    if (rd_ok) m_dout = exp_q.pop_front();
    if (wr_ok) exp_q.push_back(din);
  endtask

  // Driver: present one cycle of strobes, let the edge happen, then compare.
  task automatic step(input logic wr, input logic rd, input logic [3:0] din, input string tag);
    ui_in   = {din, rd, wr, 2'b00};
    uio_in  = 8'($urandom_range(0, 255));
    @(posedge clk);
    #1;
    model_step(wr, rd, din);
    check(tag, uo_out, exp_uo());
    ui_in = {4'h0, 2'b00, 2'($urandom_range(0, 3))};
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    ena      = 1'b1;
    ui_in    = 8'h00;
    uio_in   = 8'h00;
    rst_n    = 1'b0;
    model_reset();

    // Reset state
    #12;
    check("rst_uo_out",  uo_out,  8'h02);
    check("rst_uio_oe",  uio_oe,  8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single write then read, then a rejected read holding dout
    step(1'b1, 1'b0, 4'hA, "wr_A");
    check("wr_A_not_empty", {7'h0, uo_out[1]}, 8'h00);
    step(1'b0, 1'b1, 4'h0, "rd_A");
    check("rd_A_dout", {4'h0, uo_out[5:2]}, 8'h0A);
    step(1'b0, 1'b1, 4'h0, "rd_empty_hold");

    // Second entry confirms pointer advance
    step(1'b1, 1'b0, 4'hC, "wr_C");
    step(1'b0, 1'b1, 4'h0, "rd_C");

    // Fill to full, overflow write, drain in order
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 4'(i), "fill");
    check("full_after_8", {7'h0, uo_out[0]}, 8'h01);
    step(1'b1, 1'b0, 4'hF, "wr_overflow");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1, 4'h0, "drain");
      check("drain_order", {4'h0, uo_out[5:2]}, 8'(i));
    end
    check("empty_after_drain", {7'h0, uo_out[1]}, 8'h01);

    // Simultaneous read/write with 3 stored, across pointer wrap
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 4'(4'h5 + i), "pre3");
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'($urandom_range(0, 15)), "rdwr3");

    // Simultaneous read/write while full keeps full asserted
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), "top_up");
    step(1'b1, 1'b1, 4'h9, "rdwr_full");
    check("full_kept", {7'h0, uo_out[0]}, 8'h01);

    // Mid-stream asynchronous reset with 5 entries
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 4'h0, "empty_out");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'($urandom_range(0, 15)), "pre5");
    rst_n = 1'b0;
    #2;
    model_reset();
    check("async_rst_uo", uo_out, 8'h02);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 4'h0, "rd_after_rst");

    // Randomized stream with alternating fill-biased and drain-biased phases
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 60; i++) begin
        logic wr;
        logic rd;
        if (p % 2 == 0) begin
          wr = ($urandom_range(0, 99) < 75);
          rd = ($urandom_range(0, 99) < 35);
        end else begin
          wr = ($urandom_range(0, 99) < 35);
          rd = ($urandom_range(0, 99) < 75);
        end
        step(wr, rd, 4'($urandom_range(0, 15)), "random");
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_tt_um_monishvr_fifo
